regfile_dump: RTL

Debug readout engine for the single-cycle MIPS register file. On a `start` pulse it walks an inclusive, wrap-around range of register indices, drives the register file's second read port, snapshots each 32-bit value, and streams it out as framed bytes over a valid/ready interface. It sits beside the datapath, in front of a debug UART or trace FIFO. It is the reader counterpart to the register file's write port.

---
 rtl/mips_pkg.sv | 10 +
 rtl/regfile_dump_if.sv | 26 ++
 rtl/regfile_dump_word_serializer.sv | 71 +++++++
 rtl/regfile_dump.sv | 89 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS register-file debug readout.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, HDR, BYTE} dump_state_t;

  localparam int          REG_ADDR_W   = 5;
  localparam int          REG_DATA_W   = 32;
  localparam logic [2:0]  DUMP_HDR_TAG = 3'b101;

endpackage

// File: rtl/regfile_dump_if.sv
// Control, register-file read port and byte stream of the register dump engine.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_reg, last_reg, rd_data, out_ready,
    output rd_addr, out_valid, out_data, busy, done
  );

  modport slave (
    output start, first_reg, last_reg, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/regfile_dump_word_serializer.sv
// Emits one header byte then a snapshotted word MSB-first over valid/ready.
module word_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic [7:0]        hdr,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              last
);
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              in_hdr_q, in_hdr_d;
  logic              fire;

  assign fire = out_valid && out_ready;

  always_comb begin
    shreg_d  = shreg_q;
    hdr_d    = hdr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    in_hdr_d = in_hdr_q;
    if (load) begin
      shreg_d  = word;
      hdr_d    = hdr;
      active_d = 1'b1;
      in_hdr_d = 1'b1;
    end else if (fire) begin
      if (in_hdr_q) begin
        in_hdr_d = 1'b0;
        cnt_d    = '0;
      end else begin
        shreg_d = shreg_q << 8;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q  <= '0;
      hdr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      in_hdr_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      hdr_q    <= hdr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      in_hdr_q <= in_hdr_d;
    end
  end

  // Output is a pure function of held state, so it stays frozen while stalled.
  assign out_valid = active_q;
  assign out_data  = !active_q ? 8'h00 : (in_hdr_q ? hdr_q : shreg_q[DATA_W-1 -: 8]);
  assign last      = active_q && !in_hdr_q && (cnt_q == LAST_CNT);
endmodule

// File: rtl/regfile_dump.sv
// Walks an inclusive, wrap-around register range and streams each register as a framed word.
module regfile_dump
  import mips_pkg::*;
#(
  parameter int         DATA_W  = REG_DATA_W,
  parameter int         ADDR_W  = REG_ADDR_W,
  parameter logic [2:0] HDR_TAG = DUMP_HDR_TAG
) (
  input  logic           clk,
  input  logic           rst,
  regfile_dump_if.master bus
);
  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ser_load, ser_last, fire;
  logic [7:0]        hdr_byte;

  assign hdr_byte = 8'({HDR_TAG, cur_q});
  assign fire     = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ser_load = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        cur_d   = bus.first_reg;
        last_d  = bus.last_reg;
        busy_d  = 1'b1;
        state_d = LOAD;
      end
      // Snapshot lands on the edge leaving LOAD; a same-edge write is not seen.
      LOAD: begin
        ser_load = 1'b1;
        state_d  = HDR;
      end
      HDR:  if (fire) state_d = BYTE;
      BYTE: if (fire && ser_last) begin
        if (cur_q == last_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cur_d   = cur_q + ADDR_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .word      (bus.rd_data),
    .hdr       (hdr_byte),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_ready (bus.out_ready),
    .last      (ser_last)
  );

  assign bus.rd_addr = cur_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
